io_out_collector: RTL and testbench
===================================

// Module: io_out_collector
// PURPOSE
//  Synthesizable I/O front-end for CPU output.
//  - Produces the CPU's startIO strobe after a programmable cycle delay.
//  - Captures every (outFlag, out) word the CPU emits into a parametrised FIFO.
//  - Drains the FIFO over a valid/ready stream to a UART/host/monitor.
//  - Sits between CPU and board-level I/O; replaces bench-side delay and output sampling.
// PARAMETERS
//  WIDTH        24      data word width; matches CPU out width
//  DEPTH        16      FIFO entries; power of two, >= 2
//  CNTWIDTH     24      width of start-delay counter and captured-word counter
//  START_DELAY  481030  clock cycles from enable to startIO assertion (0 = immediate)
//  OVERWRITE    0       0: drop new word when full; 1: overwrite oldest word when full
// PORTS
//  clock          in   1                  system clock, rising edge
//  reset          in   1                  asynchronous, active-low reset
//  enable         in   1                  arms start sequencer; level-sensitive
//  startIO        out  1                  start strobe to CPU; held high once asserted
//  outFlag        in   1                  CPU output-valid flag
//  out            in   WIDTH              CPU output word
//  dataOut        out  WIDTH              FIFO head word
//  dataValid      out  1                  FIFO non-empty
//  dataReady      in   1                  consumer accepts dataOut
//  level          out  $clog2(DEPTH)+1    current FIFO occupancy, 0..DEPTH
//  captured       out  CNTWIDTH           words accepted since reset; saturating
//  overflow       out  1                  sticky: a word arrived while FIFO full
//  clearOverflow  in   1                  synchronous clear of overflow
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=IDLE; delay counter, pointers, level and captured = 0.
//   - startIO=0, dataValid=0, overflow=0.
//   - dataOut is don't-care while dataValid=0.
//   - Reset mid-transfer discards FIFO contents and restarts the sequencer.
//  Start FSM (IDLE, COUNT, RUN):
//   - IDLE: enable=1 -> COUNT with counter=0; if START_DELAY=0, go straight to RUN.
//   - COUNT: counter+1 each cycle.
//     - counter==START_DELAY-1 -> RUN.
//     - enable=0 -> IDLE, counter cleared.
//   - RUN: terminal until reset; enable ignored.
//   - startIO is registered, =1 exactly when state==RUN.
//     - It rises START_DELAY+1 edges after the edge sampling enable=1.
//  Capture (independent of FSM state):
//   - Write request on every edge where outFlag=1; out is stored at wrPtr.
//   - Read on every edge where dataValid & dataReady.
//   - dataOut = mem[rdPtr], first-word-fall-through.
//     - Word written at edge k: dataValid and dataOut valid after edge k.
//     - Zero-bubble streaming at one word per cycle.
//   - Pointers wrap modulo DEPTH. level = writes - reads, never exceeds DEPTH.
//   - Simultaneous read + write:
//     - Not full: both occur, level unchanged.
//     - Full: both occur, no overflow.
//     - Empty: write only (no read possible).
//   - Full, write, no read, OVERWRITE=0:
//     - Word dropped; pointers unchanged.
//     - overflow set; captured not incremented.
//   - Full, write, no read, OVERWRITE=1:
//     - Word stored at wrPtr; rdPtr advances; level stays DEPTH.
//     - overflow set; captured incremented.
//   - captured increments by 1 per accepted write; holds at 2^CNTWIDTH-1.
//   - overflow clears on clearOverflow=1; a same-cycle overflow event wins (stays 1).
// TESTING
//  1 START_DELAY=5, enable=1 at edge 0 -> startIO=0 through edge 5, =1 after edge 6;
//    dropping enable at edge 3 -> returns to IDLE, no startIO.
//  2 outFlag pulses with out=24'h000001,24'h000002,24'h000003, dataReady=0
//    -> level=3, dataOut=1; then dataReady=1 -> 1,2,3 on consecutive cycles, level=0.
//  3 DEPTH=4, OVERWRITE=0, 6 writes, no reads -> level=4, overflow=1, captured=4,
//    drain yields words 1..4.
//  4 DEPTH=4, OVERWRITE=1, 6 writes, no reads -> level=4, overflow=1, captured=6,
//    drain yields words 3..6.
//  5 FIFO full with outFlag=1 and dataReady=1 held 20 cycles -> level=4 every cycle,
//    overflow=0, output in order.
//  6 reset=0 asynchronously mid-stream with level=3 -> level=0, dataValid=0,
//    startIO=0 before the next edge.

Source files
------------

// File: rtl/io_out_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : io_out_collector                                              |
// | Purpose  : CPU output front-end. Raises the CPU start strobe after a     |
// |            programmable delay, captures every flagged CPU output word    |
// |            into a FIFO and drains it over a valid/ready stream.          |
// | Ports    : clock/reset      - clock, async active-low reset              |
// |            enable/startIO   - start sequencer arm / start strobe to CPU  |
// |            outFlag/out      - CPU output-valid flag and word             |
// |            dataOut/dataValid/dataReady - FWFT stream to the consumer     |
// |            level            - FIFO occupancy 0..DEPTH                    |
// |            captured         - saturating count of accepted words         |
// |            overflow/clearOverflow - sticky overflow flag and its clear   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module io_out_collector #(
  parameter int WIDTH       = 24,
  parameter int DEPTH       = 16,
  parameter int CNTWIDTH    = 24,
  parameter int START_DELAY = 481030,
  parameter bit OVERWRITE   = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  output logic                     startIO,
  input  logic                     outFlag,
  input  logic [WIDTH-1:0]         out,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     dataValid,
  input  logic                     dataReady,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNTWIDTH-1:0]      captured,
  output logic                     overflow,
  input  logic                     clearOverflow
);

  localparam int                  c_aw         = $clog2(DEPTH);
  localparam logic [c_aw:0]       c_depth      = (c_aw+1)'(DEPTH);
  // Only meaningful when START_DELAY > 0; the IDLE state bypasses COUNT otherwise.
  localparam logic [CNTWIDTH-1:0] c_delay_last = CNTWIDTH'(START_DELAY - 1);
  localparam logic [CNTWIDTH-1:0] c_cap_max    = '1;

  // --------------------------------------------------------------------------
  // Start sequencer
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNTWIDTH-1:0] dly_cnt_q, dly_cnt_d;
  logic                start_io_q, start_io_d;

  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          dly_cnt_d = '0;
          state_d   = (START_DELAY == 0) ? ST_RUN : ST_COUNT;
        end
      end
      ST_COUNT: begin
        // Losing enable aborts the countdown even on its final cycle.
        if (!enable) begin
          state_d   = ST_IDLE;
          dly_cnt_d = '0;
        end else if (dly_cnt_q == c_delay_last) begin
          state_d = ST_RUN;
        end else begin
          dly_cnt_d = dly_cnt_q + 1'b1;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    // Registered copy of the RUN state: the strobe appears one edge after RUN
    // is entered, giving START_DELAY+1 edges from the first enable sample.
    start_io_d = (state_q == ST_RUN);
  end

  // --------------------------------------------------------------------------
  // Capture FIFO
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [c_aw-1:0]     wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]     rd_ptr_q, rd_ptr_d;
  logic [c_aw:0]       level_q, level_d;
  logic [CNTWIDTH-1:0] captured_q, captured_d;
  logic                overflow_q, overflow_d;

  logic full_w, empty_w, do_read_w, do_write_w, ovf_event_w, evict_w;

  always_comb begin
    full_w      = (level_q == c_depth);
    empty_w     = (level_q == '0);
    do_read_w   = !empty_w && dataReady;
    // A full FIFO still accepts a word when the head is leaving this cycle,
    // or unconditionally in overwrite mode.
    do_write_w  = outFlag && (!full_w || do_read_w || OVERWRITE);
    ovf_event_w = outFlag && full_w && !do_read_w;
    // Overwrite of the oldest entry: the read pointer must skip it.
    evict_w     = do_write_w && full_w && !do_read_w;

    wr_ptr_d = do_write_w ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = (do_read_w || evict_w) ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d = level_q;
    if (do_write_w && !do_read_w && !full_w) begin
      level_d = level_q + 1'b1;
    end else if (do_read_w && !do_write_w) begin
      level_d = level_q - 1'b1;
    end

    captured_d = captured_q;
    if (do_write_w && (captured_q != c_cap_max)) begin
      captured_d = captured_q + 1'b1;
    end

    // A same-cycle overflow event takes priority over the clear.
    if (ovf_event_w) begin
      overflow_d = 1'b1;
    end else if (clearOverflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      dly_cnt_q  <= '0;
      start_io_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      captured_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      start_io_q <= start_io_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      captured_q <= captured_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; contents are only visible while dataValid is high.
  always_ff @(posedge clock) begin
    if (do_write_w) begin
      mem_q[wr_ptr_q] <= out;
    end
  end

  assign startIO   = start_io_q;
  assign dataOut   = mem_q[rd_ptr_q];
  assign dataValid = !empty_w;
  assign level     = level_q;
  assign captured  = captured_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_io_out_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_io_out_collector                                           |
// | Purpose  : Self-checking bench for io_out_collector. Two instances share |
// |            stimulus: dut0 (DEPTH=4, START_DELAY=5, drop on full) and     |
// |            dut1 (DEPTH=4, START_DELAY=0, overwrite, 3-bit counter).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_io_out_collector;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        outFlag = 1'b0;
  logic [23:0] out_w = '0;
  logic        dataReady = 1'b0;
  logic        clearOverflow = 1'b0;

  logic        s0_startIO, s0_dataValid, s0_overflow;
  logic [23:0] s0_dataOut, s0_captured;
  logic [2:0]  s0_level;
  logic        s1_startIO, s1_dataValid, s1_overflow;
  logic [23:0] s1_dataOut;
  logic [2:0]  s1_captured;
  logic [2:0]  s1_level;

  always #5 clock = ~clock;

  io_out_collector #(.WIDTH(24), .DEPTH(4), .CNTWIDTH(24), .START_DELAY(5), .OVERWRITE(1'b0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .startIO(s0_startIO),
    .outFlag(outFlag), .out(out_w), .dataOut(s0_dataOut), .dataValid(s0_dataValid),
    .dataReady(dataReady), .level(s0_level), .captured(s0_captured),
    .overflow(s0_overflow), .clearOverflow(clearOverflow)
  );

  io_out_collector #(.WIDTH(24), .DEPTH(4), .CNTWIDTH(3), .START_DELAY(0), .OVERWRITE(1'b1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .startIO(s1_startIO),
    .outFlag(outFlag), .out(out_w), .dataOut(s1_dataOut), .dataValid(s1_dataValid),
    .dataReady(dataReady), .level(s1_level), .captured(s1_captured),
    .overflow(s1_overflow), .clearOverflow(clearOverflow)
  );

  // Reference model state, one slot per instance.
  logic [23:0] mq [2][$];
  int          mcap    [2];
  bit          movf    [2];
  int          consec  [2];
  bit          run     [2];
  bit          sio     [2];

  int tests = 0;
  int fails = 0;

  function automatic int dly_of(input int id);
    return (id == 0) ? 5 : 0;
  endfunction
  function automatic bit ow_of(input int id);
    return (id == 0) ? 1'b0 : 1'b1;
  endfunction
  function automatic int capmax_of(input int id);
    return (id == 0) ? 24'hFFFFFF : 7;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      mq[id].delete();
      mcap[id]   = 0;
      movf[id]   = 1'b0;
      consec[id] = 0;
      run[id]    = 1'b0;
      sio[id]    = 1'b0;
    end
  endtask

  // One rising edge of behaviour, from the inputs present at that edge.
  task automatic model_edge();
    for (int id = 0; id < 2; id++) begin
      int n;
      bit rd;
      bit ev;
      // startIO shows the run condition one edge late.
      sio[id] = run[id];
      if (!run[id]) begin
        consec[id] = enable ? consec[id] + 1 : 0;
        if (consec[id] == dly_of(id) + 1) run[id] = 1'b1;
      end
      n  = mq[id].size();
      rd = (n > 0) && dataReady;
      ev = 1'b0;
      if (rd) void'(mq[id].pop_front());
      if (outFlag) begin
        if (n < D || rd) begin
          mq[id].push_back(out_w);
          if (mcap[id] < capmax_of(id)) mcap[id]++;
        end else begin
          ev = 1'b1;
          if (ow_of(id)) begin
            void'(mq[id].pop_front());
            mq[id].push_back(out_w);
            if (mcap[id] < capmax_of(id)) mcap[id]++;
          end
        end
      end
      if (ev) movf[id] = 1'b1;
      else if (clearOverflow) movf[id] = 1'b0;
    end
  endtask

  task automatic check_dut(input int id, input logic s, input logic [2:0] lvl, input logic v,
                           input logic [23:0] dout, input logic [23:0] cap, input logic ovf);
    check($sformatf("d%0d.startIO", id), 32'(s), 32'(sio[id]));
    check($sformatf("d%0d.level", id), 32'(lvl), 32'(mq[id].size()));
    check($sformatf("d%0d.dataValid", id), 32'(v), 32'(mq[id].size() > 0));
    if (mq[id].size() > 0) check($sformatf("d%0d.dataOut", id), 32'(dout), 32'(mq[id][0]));
    check($sformatf("d%0d.captured", id), 32'(cap), 32'(mcap[id]));
    check($sformatf("d%0d.overflow", id), 32'(ovf), 32'(movf[id]));
  endtask

  task automatic check_all();
    check_dut(0, s0_startIO, s0_level, s0_dataValid, s0_dataOut, s0_captured, s0_overflow);
    check_dut(1, s1_startIO, s1_level, s1_dataValid, s1_dataOut, {21'd0, s1_captured}, s1_overflow);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    outFlag = 1'b0;
    dataReady = 1'b0;
    clearOverflow = 1'b0;
    repeat (2) @(negedge clock);
    model_reset();
    reset = 1'b1;
    check_all();
  endtask

  initial begin
    do_reset();

    // Start sequencer: aborted countdown, then a full one.
    enable = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    repeat (3) tick();
    check("t1.abort_no_start", 32'(s0_startIO), 32'd0);
    enable = 1'b1;
    repeat (6) tick();
    check("t1.low_after_edge5", 32'(s0_startIO), 32'd0);
    tick();
    check("t1.high_after_edge6", 32'(s0_startIO), 32'd1);
    repeat (2) tick();

    // Three words buffered, then streamed out back to back.
    for (int v = 1; v <= 3; v++) begin
      outFlag = 1'b1;
      out_w   = 24'(v);
      tick();
    end
    outFlag = 1'b0;
    tick();
    check("t2.level3", 32'(s0_level), 32'd3);
    check("t2.head1", 32'(s0_dataOut), 32'd1);
    dataReady = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      check("t2.stream", 32'(s0_dataOut), 32'(v));
      tick();
    end
    check("t2.level0", 32'(s0_level), 32'd0);
    dataReady = 1'b0;

    // Six writes into a 4-deep FIFO: drop (dut0) versus overwrite (dut1).
    do_reset();
    for (int v = 1; v <= 6; v++) begin
      outFlag = 1'b1;
      out_w   = 24'(v);
      tick();
    end
    outFlag = 1'b0;
    check("t3.level", 32'(s0_level), 32'd4);
    check("t3.overflow", 32'(s0_overflow), 32'd1);
    check("t3.captured", 32'(s0_captured), 32'd4);
    check("t4.level", 32'(s1_level), 32'd4);
    check("t4.overflow", 32'(s1_overflow), 32'd1);
    check("t4.captured", 32'(s1_captured), 32'd6);
    dataReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3.drain", 32'(s0_dataOut), 32'(i + 1));
      check("t4.drain", 32'(s1_dataOut), 32'(i + 3));
      tick();
    end
    dataReady = 1'b0;

    // Full FIFO with simultaneous read and write every cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      outFlag = 1'b1;
      out_w   = 24'(16 + i);
      tick();
    end
    dataReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      out_w = 24'(100 + i);
      tick();
      check("t5.level_d0", 32'(s0_level), 32'd4);
      check("t5.level_d1", 32'(s1_level), 32'd4);
      check("t5.no_ovf", 32'(s0_overflow), 32'd0);
    end
    outFlag   = 1'b0;
    dataReady = 1'b0;

    // Asynchronous reset in the middle of a cycle with three words queued.
    do_reset();
    for (int v = 1; v <= 3; v++) begin
      outFlag = 1'b1;
      out_w   = 24'(v);
      tick();
    end
    outFlag = 1'b0;
    check("t6.pre_level", 32'(s0_level), 32'd3);
    check("t6.pre_start_d1", 32'(s1_startIO), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6.level_d0", 32'(s0_level), 32'd0);
    check("t6.valid_d0", 32'(s0_dataValid), 32'd0);
    check("t6.level_d1", 32'(s1_level), 32'd0);
    check("t6.valid_d1", 32'(s1_dataValid), 32'd0);
    check("t6.start_d1", 32'(s1_startIO), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    check_all();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      enable        = ($urandom_range(0, 19) != 0);
      outFlag       = ($urandom_range(0, 99) < 60);
      dataReady     = ($urandom_range(0, 99) < 45);
      clearOverflow = ($urandom_range(0, 99) < 10);
      out_w         = 24'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
